shift_counter_gen: RTL and testbench

Parametrised successor to the team's fixed 4-bit Johnson counter. Implements a WIDTH-bit shift-register counter selectable at run time between Johnson (twisted-ring, 2*WIDTH states) and ring (one-hot, WIDTH states) modes. Adds enable, up/down direction, synchronous load, illegal-state self-correction and a wrap pulse. Used as a cheap glitch-free phase/sequence generator in the counter library.

---
 rtl/shcnt_pkg.sv | 17 +
 rtl/shcnt_legal_chk.sv | 50 +++++
 rtl/shift_counter_gen.sv | 147 ++++++++++++++
 tb/tb_shift_counter_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/shcnt_pkg.sv
// Shared constants and helpers for the shift-register counter family.
package shcnt_pkg;

  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;

  localparam int unsigned MAX_WIDTH = 32;

  // Home value: all zeros for Johnson, LSB set for ring; caller truncates to its width.
  function automatic logic [MAX_WIDTH-1:0] home_val(input logic mode, input int unsigned width);
    home_val = '0;
    if (mode == MODE_RING && width != 0) home_val[0] = 1'b1;
  endfunction

endpackage

// File: rtl/shcnt_legal_chk.sv
// Combinational legality check of a counter state; with SHCNT_PHASE_EN it also
// decodes the state's position in the up-sequence (0 for illegal states).
module shcnt_legal_chk
  import shcnt_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             mode_i,
  output logic             legal_c
`ifdef SHCNT_PHASE_EN
  ,
  output logic [$clog2(2*WIDTH)-1:0] phase_c
`endif
);

  int unsigned trans;
  int unsigned ones;

  // Johnson states have at most one 0/1 boundary; ring states are one-hot.
  always_comb begin
    trans = 0;
    ones  = 0;
    for (int i = 0; i < int'(WIDTH) - 1; i++) trans = trans + 32'(q_i[i] ^ q_i[i+1]);
    for (int i = 0; i < int'(WIDTH); i++) ones = ones + 32'(q_i[i]);
    legal_c = (mode_i == MODE_RING) ? (ones == 1) : (trans <= 1);
  end

`ifdef SHCNT_PHASE_EN
  localparam int unsigned PW = $clog2(2*WIDTH);

  int unsigned set_bit;
  int unsigned phase_int;

  // Johnson fills from the MSB for the first half, then drains from the MSB.
  always_comb begin
    set_bit = 0;
    for (int i = 0; i < int'(WIDTH); i++) if (q_i[i]) set_bit = 32'(i);
    phase_int = 0;
    if (mode_i == MODE_RING) begin
      phase_int = (set_bit == 0) ? 0 : WIDTH - set_bit;
    end else if (ones != 0) begin
      phase_int = q_i[WIDTH-1] ? ones : 2*WIDTH - ones;
    end
    if (!legal_c) phase_int = 0;
    phase_c = PW'(phase_int);
  end
`endif

endmodule

// File: rtl/shift_counter_gen.sv
// WIDTH-bit Johnson/ring counter with load, direction, self-correction and wrap.
// Optional SHCNT_PHASE_EN adds a registered sequence-position output.
module shift_counter_gen
  import shcnt_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             err
`ifdef SHCNT_PHASE_EN
  ,
  output logic [$clog2(2*WIDTH)-1:0] phase
`endif
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] home_new;
  logic [WIDTH-1:0] home_cur;
  logic [WIDTH-1:0] step_val;
  logic             cur_legal;

  assign home_new = WIDTH'(home_val(mode, WIDTH));
  assign home_cur = WIDTH'(home_val(mode_q, WIDTH));

`ifdef SHCNT_PHASE_EN
  localparam int unsigned PW = $clog2(2*WIDTH);

  logic [PW-1:0] phase_q, phase_d;
  logic [PW-1:0] cur_phase;
  logic [PW-1:0] ld_phase;
  logic [PW-1:0] step_phase;
  logic          ld_legal;
  int unsigned   seq_len;

  shcnt_legal_chk #(.WIDTH(WIDTH)) u_chk_q (
    .q_i     (q_q),
    .mode_i  (mode_q),
    .legal_c (cur_legal),
    .phase_c (cur_phase)
  );

  shcnt_legal_chk #(.WIDTH(WIDTH)) u_chk_ld (
    .q_i     (load_val),
    .mode_i  (mode_q),
    .legal_c (ld_legal),
    .phase_c (ld_phase)
  );

  // Position after one step, modulo the sequence length of the current mode.
  always_comb begin
    seq_len = (mode_q == MODE_RING) ? WIDTH : 2*WIDTH;
    if (dir == DIR_DOWN)
      step_phase = (cur_phase == '0) ? PW'(seq_len - 1) : PW'(32'(cur_phase) - 1);
    else
      step_phase = (32'(cur_phase) + 1 == seq_len) ? '0 : PW'(32'(cur_phase) + 1);
  end

  assign phase = phase_q;
`else
  shcnt_legal_chk #(.WIDTH(WIDTH)) u_chk_q (
    .q_i     (q_q),
    .mode_i  (mode_q),
    .legal_c (cur_legal)
  );
`endif

  always_comb begin
    step_val = q_q;
    case ({mode_q, dir})
      {MODE_JOHNSON, DIR_UP}:   step_val = {~q_q[0], q_q[WIDTH-1:1]};
      {MODE_JOHNSON, DIR_DOWN}: step_val = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      {MODE_RING, DIR_UP}:      step_val = {q_q[0], q_q[WIDTH-1:1]};
      default:                  step_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
    endcase
  end

  // Mode change > load > correction > step > hold.
  always_comb begin
    q_d    = q_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
`ifdef SHCNT_PHASE_EN
    phase_d = phase_q;
`endif
    if (mode != mode_q) begin
      mode_d = mode;
      q_d    = home_new;
`ifdef SHCNT_PHASE_EN
      phase_d = '0;
`endif
    end else if (load) begin
      q_d = load_val;
`ifdef SHCNT_PHASE_EN
      phase_d = ld_legal ? ld_phase : '0;
`endif
    end else if (!cur_legal) begin
      q_d   = home_cur;
      err_d = 1'b1;
`ifdef SHCNT_PHASE_EN
      phase_d = '0;
`endif
    end else if (en) begin
      q_d    = step_val;
      wrap_d = (step_val == home_cur);
`ifdef SHCNT_PHASE_EN
      phase_d = step_phase;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      mode_q <= MODE_JOHNSON;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef SHCNT_PHASE_EN
      phase_q <= '0;
`endif
    end else begin
      q_q    <= q_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
`ifdef SHCNT_PHASE_EN
      phase_q <= phase_d;
`endif
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_shift_counter_gen.sv
// Bench for shift_counter_gen: directed vector table, async-reset sequence and
// randomized run against a sequence-index reference model.
module tb_shift_counter_gen;

  localparam int W  = 4;
  localparam int N2 = 2 * W;

  logic         clk;
  logic         reset;
  logic         en, dir, mode, load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         wrap, err;
`ifdef SHCNT_PHASE_EN
  logic [$clog2(N2)-1:0] phase;
`endif

  shift_counter_gen #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .wrap     (wrap),
    .err      (err)
`ifdef SHCNT_PHASE_EN
    ,
    .phase    (phase)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic         en, dir, mode, load;
    logic [W-1:0] lv;
    logic [W-1:0] exp_q;
    logic         exp_wrap, exp_err;
  } vec_t;

  vec_t tbl[$];

  // Reference model: state is the value plus its index in the up-sequence.
  logic [W-1:0] m_q;
  logic         m_mode, m_wrap, m_err;
  int           m_phase;

  function automatic logic [W-1:0] seq_val(logic md, int k);
    int v;
    if (md) v = (k == 0) ? 1 : (1 << (W - k));
    else if (k <= W) v = ((1 << k) - 1) << (W - k);
    else v = (1 << (N2 - k)) - 1;
    return W'(v);
  endfunction

  function automatic int idx_of(logic md, logic [W-1:0] v);
    int n = md ? W : N2;
    for (int k = 0; k < n; k++) if (seq_val(md, k) == v) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_q = '0; m_mode = 1'b0; m_wrap = 1'b0; m_err = 1'b0; m_phase = 0;
  endtask

  task automatic model_step();
    int k, n;
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (mode != m_mode) begin
      m_mode = mode;
      m_q    = seq_val(mode, 0);
    end else if (load) begin
      m_q = load_val;
    end else begin
      k = idx_of(m_mode, m_q);
      if (k < 0) begin
        m_q   = seq_val(m_mode, 0);
        m_err = 1'b1;
      end else if (en) begin
        n      = m_mode ? W : N2;
        k      = dir ? (k + n - 1) % n : (k + 1) % n;
        m_q    = seq_val(m_mode, k);
        m_wrap = (k == 0);
      end
    end
    k       = idx_of(m_mode, m_q);
    m_phase = (k < 0) ? 0 : k;
  endtask

  task automatic check(string name, logic [W-1:0] eq, logic ew, logic ee);
    n_vec++;
    if (q !== eq || wrap !== ew || err !== ee) begin
      n_err++;
      $display("FAIL %s: got q=%b wrap=%b err=%b, want q=%b wrap=%b err=%b",
               name, q, wrap, err, eq, ew, ee);
    end
`ifdef SHCNT_PHASE_EN
    n_vec++;
    if (int'(phase) != m_phase) begin
      n_err++;
      $display("FAIL %s_phase: got %0d, want %0d", name, phase, m_phase);
    end
`endif
  endtask

  task automatic apply(logic e, logic d, logic m, logic l, logic [W-1:0] lv);
    @(negedge clk);
    en = e; dir = d; mode = m; load = l; load_val = lv;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic add(logic e, logic d, logic m, logic l, logic [W-1:0] lv,
                     logic [W-1:0] eq, logic ew, logic ee);
    vec_t v;
    v.en = e; v.dir = d; v.mode = m; v.load = l; v.lv = lv;
    v.exp_q = eq; v.exp_wrap = ew; v.exp_err = ee;
    tbl.push_back(v);
  endtask

  initial begin
    // Johnson up through one full lap
    add(1,0,0,0,4'b0000, 4'b1000,0,0);
    add(1,0,0,0,4'b0000, 4'b1100,0,0);
    add(1,0,0,0,4'b0000, 4'b1110,0,0);
    add(1,0,0,0,4'b0000, 4'b1111,0,0);
    add(1,0,0,0,4'b0000, 4'b0111,0,0);
    add(1,0,0,0,4'b0000, 4'b0011,0,0);
    add(1,0,0,0,4'b0000, 4'b0001,0,0);
    add(1,0,0,0,4'b0000, 4'b0000,1,0);
    // ring down, then flip direction at 0100
    add(1,1,1,0,4'b0000, 4'b0001,0,0);
    add(1,1,1,0,4'b0000, 4'b0010,0,0);
    add(1,1,1,0,4'b0000, 4'b0100,0,0);
    add(1,1,1,0,4'b0000, 4'b1000,0,0);
    add(1,1,1,0,4'b0000, 4'b0001,1,0);
    add(1,1,1,0,4'b0000, 4'b0010,0,0);
    add(1,1,1,0,4'b0000, 4'b0100,0,0);
    add(1,0,1,0,4'b0000, 4'b0010,0,0);
    // illegal Johnson load, corrected with en ignored
    add(1,0,0,0,4'b0000, 4'b0000,0,0);
    add(1,0,0,1,4'b0101, 4'b0101,0,0);
    add(1,0,0,0,4'b0000, 4'b0000,0,1);
    add(1,0,0,0,4'b0000, 4'b1000,0,0);
    add(1,0,0,0,4'b0000, 4'b1100,0,0);
    add(1,0,0,0,4'b0000, 4'b1110,0,0);
    // mode change beats load
    add(1,0,1,1,4'b0101, 4'b0001,0,0);
    add(0,0,1,0,4'b0000, 4'b0001,0,0);
    // illegal ring load corrected even with en low
    add(0,0,1,1,4'b0011, 4'b0011,0,0);
    add(0,0,1,0,4'b0000, 4'b0001,0,1);
    // Johnson down wraps back to home
    add(0,0,0,0,4'b0000, 4'b0000,0,0);
    add(1,1,0,0,4'b0000, 4'b0001,0,0);
    add(1,0,0,0,4'b0000, 4'b0000,1,0);

    reset = 1'b0; en = 0; dir = 0; mode = 0; load = 0; load_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset", 4'b0000, 1'b0, 1'b0);
    @(negedge clk) reset = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].en, tbl[i].dir, tbl[i].mode, tbl[i].load, tbl[i].lv);
      check($sformatf("vec%0d", i), tbl[i].exp_q, tbl[i].exp_wrap, tbl[i].exp_err);
    end

    // Asynchronous reset in mid-cycle from 0111
    repeat (5) apply(1, 0, 0, 0, 4'b0000);
    check("pre_rst", 4'b0111, 1'b0, 1'b0);
    #2 reset = 1'b0;
    model_reset();
    #1 check("async_rst", 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("rst_hold", 4'b0000, 1'b0, 1'b0);
    @(negedge clk) reset = 1'b1;

    // Randomized run against the model
    begin
      logic md = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(39) == 0) md = ~md;
        apply(($urandom_range(3) != 0), 1'($urandom_range(1)), md,
              ($urandom_range(9) == 0), W'($urandom));
        check($sformatf("rand%0d", i), m_q, m_wrap, m_err);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
